fft_out_reorder: RTL and testbench

FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

---
 rtl/fft_out_reorder_pkg.sv | 29 ++
 rtl/fft_reorder_ram.sv | 44 ++++
 rtl/fft_out_reorder.sv | 189 ++++++++++++++++++
 tb/tb_fft_out_reorder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_out_reorder_pkg.sv
// ============================================================================
//  Module      : fft_out_reorder_pkg
//  Description : Shared FFT constants, reader state encoding and the
//                bit-reversal helper used by the FFT stage modules.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_out_reorder_pkg;

    localparam int N_POINT = 128;
    localparam int LOG2N   = 7;
    localparam int DW      = 38;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } rd_state_t;

    // Reverse the low 'width' bits of 'value'; bits above 'width' return 0.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
        logic [31:0] rev;
        rev = {<<{value}};
        return rev >> (32 - width);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fft_reorder_ram.sv
// ============================================================================
//  Module      : fft_reorder_ram
//  Description : Simple dual-port RAM, synchronous write, registered read,
//                no reset, written so synthesis maps it onto block RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_reorder_ram #(
    parameter int DEPTH = 128,
    parameter int AW    = 7,
    parameter int WIDTH = 76
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port; output holds between reads
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/fft_out_reorder.sv
// ============================================================================
//  Module      : fft_out_reorder
//  Description : Ping-pong reorder buffer turning bit-reversed FFT output
//                into natural order with a fixed 2-cycle latency after the
//                last sample of each frame.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_out_reorder #(
    parameter int N_POINT = fft_out_reorder_pkg::N_POINT,
    parameter int LOG2N   = fft_out_reorder_pkg::LOG2N,
    parameter int DW      = fft_out_reorder_pkg::DW
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic                 iData_valid,
    input  logic signed [DW-1:0] iData_Re,
    input  logic signed [DW-1:0] iData_Im,
    output logic                 oData_valid,
    output logic signed [DW-1:0] oData_Re,
    output logic signed [DW-1:0] oData_Im,
    output logic [LOG2N-1:0]     oIndex,
    output logic                 oFrame_start,
    output logic                 oOverflow
);

    import fft_out_reorder_pkg::*;

    localparam logic [LOG2N-1:0] c_last_addr = LOG2N'(N_POINT - 1);

    // Write side
    logic [LOG2N-1:0]  r_wr_cnt;
    logic              r_wr_bank;
    logic [LOG2N-1:0]  w_wr_addr;
    logic              w_wr_last;
    logic [2*DW-1:0]   w_wr_data;
    logic [1:0]        r_full;
    logic              r_overflow;

    // Read side
    rd_state_t         r_state;
    rd_state_t         w_next_state;
    logic [LOG2N-1:0]  r_rd_cnt;
    logic              r_rd_bank;
    logic              w_rd_fire;
    logic              w_rd_bank;
    logic [LOG2N-1:0]  w_rd_addr;
    logic              w_rd_last;

    // Read pipeline stage aligned with RAM output
    logic              r_pipe_valid;
    logic [LOG2N-1:0]  r_pipe_idx;
    logic              r_pipe_bank;
    logic [2*DW-1:0]   w_bank_rdata [2];
    logic [2*DW-1:0]   w_rd_data;

    assign w_wr_addr = LOG2N'(bitrev(32'(r_wr_cnt), LOG2N));
    assign w_wr_last = iData_valid && (r_wr_cnt == c_last_addr);
    assign w_wr_data = {iData_Re, iData_Im};
    assign w_rd_data = w_bank_rdata[r_pipe_bank];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_reorder_ram #(
            .DEPTH (N_POINT),
            .AW    (LOG2N),
            .WIDTH (2*DW)
        ) u_ram (
            .clk     (iClk),
            .i_we    (iData_valid && (r_wr_bank == 1'(b))),
            .i_waddr (w_wr_addr),
            .i_wdata (w_wr_data),
            .i_re    (w_rd_fire && (w_rd_bank == 1'(b))),
            .i_raddr (w_rd_addr),
            .o_rdata (w_bank_rdata[b])
        );
    end

    // Write counter, bank toggle, full-flag bookkeeping and sticky overflow
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_wr_cnt   <= '0;
            r_wr_bank  <= 1'b0;
            r_full     <= 2'b00;
            r_overflow <= 1'b0;
        end else begin
            if (iData_valid) begin
                r_wr_cnt <= r_wr_cnt + LOG2N'(1);
            end
            if (w_wr_last) begin
                r_wr_bank <= ~r_wr_bank;
            end
            // Clear on the last read, then set on frame completion so a
            // collision keeps the flag set.
            if (w_rd_last && !w_rd_bank) r_full[0] <= 1'b0;
            if (w_rd_last &&  w_rd_bank) r_full[1] <= 1'b0;
            if (w_wr_last && !r_wr_bank) r_full[0] <= 1'b1;
            if (w_wr_last &&  r_wr_bank) r_full[1] <= 1'b1;
            if (w_wr_last && r_full[r_wr_bank]) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Reader next state: IDLE starts the first read in the same cycle it
    // sees a full bank, which is what keeps latency at two cycles and lets
    // back-to-back frames stream without a gap.
    always_comb begin
        w_next_state = r_state;
        w_rd_fire    = 1'b0;
        w_rd_bank    = r_rd_bank;
        w_rd_addr    = r_rd_cnt;
        w_rd_last    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|r_full) begin
                    w_rd_fire    = 1'b1;
                    w_rd_bank    = r_full[r_rd_bank] ? r_rd_bank : ~r_rd_bank;
                    w_rd_addr    = '0;
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_rd_fire = 1'b1;
                if (r_rd_cnt == c_last_addr) begin
                    w_rd_last = 1'b1;
                    if (!r_full[~r_rd_bank]) begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Reader state register; rd_bank advances to the other bank after each frame
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state   <= S_IDLE;
            r_rd_cnt  <= '0;
            r_rd_bank <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_rd_fire) begin
                r_rd_cnt  <= w_rd_addr + LOG2N'(1);
                r_rd_bank <= w_rd_last ? ~w_rd_bank : w_rd_bank;
            end
        end
    end

    // Track which bank and index the RAM output belongs to
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_pipe_valid <= 1'b0;
            r_pipe_idx   <= '0;
            r_pipe_bank  <= 1'b0;
        end else begin
            r_pipe_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_pipe_idx  <= w_rd_addr;
                r_pipe_bank <= w_rd_bank;
            end
        end
    end

    // Output register; data and index hold while no sample is presented
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oData_valid  <= 1'b0;
            oData_Re     <= '0;
            oData_Im     <= '0;
            oIndex       <= '0;
            oFrame_start <= 1'b0;
        end else begin
            oData_valid  <= r_pipe_valid;
            oFrame_start <= r_pipe_valid && (r_pipe_idx == '0);
            if (r_pipe_valid) begin
                oData_Re <= w_rd_data[2*DW-1:DW];
                oData_Im <= w_rd_data[DW-1:0];
                oIndex   <= r_pipe_idx;
            end
        end
    end

    assign oOverflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_fft_out_reorder.sv
// ============================================================================
//  Module      : tb_fft_out_reorder
//  Description : Self-checking bench for fft_out_reorder against a
//                frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_out_reorder;

    localparam int N     = 128;
    localparam int LOG2N = 7;
    localparam int DW    = 38;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic [DW-1:0]    in_re = '0;
    logic [DW-1:0]    in_im = '0;
    logic             out_valid;
    logic [DW-1:0]    out_re;
    logic [DW-1:0]    out_im;
    logic [LOG2N-1:0] out_idx;
    logic             out_fs;
    logic             overflow;

    always #5 clk = ~clk;

    fft_out_reorder #(
        .N_POINT (N),
        .LOG2N   (LOG2N),
        .DW      (DW)
    ) dut (
        .iClk         (clk),
        .iRst_n       (rst_n),
        .iData_valid  (in_valid),
        .iData_Re     (in_re),
        .iData_Im     (in_im),
        .oData_valid  (out_valid),
        .oData_Re     (out_re),
        .oData_Im     (out_im),
        .oIndex       (out_idx),
        .oFrame_start (out_fs),
        .oOverflow    (overflow)
    );

    typedef struct {
        int unsigned      cyc;
        logic [DW-1:0]    re;
        logic [DW-1:0]    im;
        logic [LOG2N-1:0] idx;
    } exp_t;

    exp_t             exp_q[$];
    logic [DW-1:0]    frm_re [N];
    logic [DW-1:0]    frm_im [N];
    int               wr_j = 0;
    int unsigned      edge_cnt = 0;
    logic [DW-1:0]    last_re = '0;
    logic [DW-1:0]    last_im = '0;
    logic [LOG2N-1:0] last_idx = '0;
    int               n_cmp = 0;
    int               n_err = 0;

    function automatic int rev7(input int v);
        int r;
        r = 0;
        for (int b = 0; b < LOG2N; b++) begin
            if ((v & (1 << b)) != 0) r = r | (1 << (LOG2N - 1 - b));
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, expv, edge_cnt);
        end
    endtask

    // Reference model and output monitor. Inputs change just after a rising
    // edge, so what is seen here is what the next rising edge accepts.
    always @(negedge clk) begin
        exp_t e;
        edge_cnt++;
        if (!rst_n) begin
            check("rst_valid", out_valid, 0);
            check("rst_re",    out_re,    0);
            check("rst_im",    out_im,    0);
            check("rst_idx",   out_idx,   0);
            check("rst_fs",    out_fs,    0);
            check("rst_ovf",   overflow,  0);
            wr_j = 0;
            exp_q.delete();
            last_re = '0; last_im = '0; last_idx = '0;
        end else begin
            if (exp_q.size() > 0 && exp_q[0].cyc == edge_cnt) begin
                e = exp_q.pop_front();
                check("valid", out_valid, 1);
                check("re",    out_re,  e.re);
                check("im",    out_im,  e.im);
                check("index", out_idx, e.idx);
                check("fstart", out_fs, (e.idx == 0) ? 1 : 0);
                last_re = e.re; last_im = e.im; last_idx = e.idx;
            end else begin
                check("valid_low", out_valid, 0);
                check("fstart_low", out_fs, 0);
                check("hold_re",  out_re,  last_re);
                check("hold_im",  out_im,  last_im);
                check("hold_idx", out_idx, last_idx);
            end
            if (in_valid) begin
                frm_re[wr_j] = in_re;
                frm_im[wr_j] = in_im;
                wr_j++;
                if (wr_j == N) begin
                    // Last sample lands on edge edge_cnt+1; bin k was input
                    // sample rev7(k) and leaves k+2 edges later.
                    for (int k = 0; k < N; k++) begin
                        e.cyc = edge_cnt + 1 + 2 + k;
                        e.re  = frm_re[rev7(k)];
                        e.im  = frm_im[rev7(k)];
                        e.idx = LOG2N'(k);
                        exp_q.push_back(e);
                    end
                    wr_j = 0;
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [DW-1:0] re, input logic [DW-1:0] im);
        @(posedge clk);
        #1;
        in_valid = v;
        in_re    = re;
        in_im    = im;
    endtask

    function automatic logic [DW-1:0] rnd();
        return DW'({$urandom, $urandom});
    endfunction

    task automatic idle(input int n);
        repeat (n) drive(1'b0, rnd(), rnd());
    endtask

    // mode 0: ramp Re=off+bitrev(j), Im=-(off+bitrev(j)); mode 1: random
    // data with the extreme pair at j=1. gapped: ~50% idle cycles inserted.
    task automatic send_frame(input int mode, input int off, input bit gapped, input int count);
        logic [DW-1:0] re, im;
        for (int j = 0; j < count; j++) begin
            while (gapped && $urandom_range(0, 1) == 1) drive(1'b0, rnd(), rnd());
            if (mode == 0) begin
                re = DW'(off + rev7(j));
                im = DW'(-(off + rev7(j)));
            end else if (j == 1) begin
                re = {1'b0, {(DW-1){1'b1}}};
                im = {1'b1, {(DW-1){1'b0}}};
            end else begin
                re = rnd();
                im = rnd();
            end
            drive(1'b1, re, im);
        end
    endtask

    task automatic pulse_reset(input int n);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5);

        // Single ramp frame, gap-free
        send_frame(0, 0, 1'b0, N);
        idle(140);

        // Four back-to-back frames with distinct offsets
        send_frame(0, 0,    1'b0, N);
        send_frame(0, 1000, 1'b0, N);
        send_frame(0, 2000, 1'b0, N);
        send_frame(0, 3000, 1'b0, N);
        idle(140);

        // Gapped ramp
        send_frame(0, 0, 1'b1, N);
        idle(140);

        // Reset after input sample 60 of a frame, then a full frame
        send_frame(0, 5000, 1'b0, 61);
        pulse_reset(4);
        idle(3);
        send_frame(0, 7000, 1'b0, N);
        idle(140);

        // Reset while a frame is being drained
        send_frame(1, 0, 1'b0, N);
        idle(50);
        pulse_reset(3);
        idle(3);

        // Extreme values and random data, gap-free and gapped
        send_frame(1, 0, 1'b0, N);
        send_frame(1, 0, 1'b1, N);
        send_frame(1, 0, 1'b0, N);
        idle(140);

        @(negedge clk);
        check("overflow",   overflow, 0);
        check("drained",    exp_q.size(), 0);
        check("end_valid",  out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
